// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a FIFO. Frames are queued through
// wr_en/wr_data (wr_ready, count, empty, full, ovf report FIFO state) and
// serialised on tx, one per start pulse or back-to-back while auto_en.
// parity_mode/stop2 are latched per frame; busy/done frame the transmission.
// Optional `UART_TX_BREAK_EN adds a brk input that holds tx low while idle.
module uart_tx_fifo #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic                     start,
    input  logic                     auto_en,
    input  logic [1:0]               parity_mode,
    input  logic                     stop2,
`ifdef UART_TX_BREAK_EN
    input  logic                     brk,
`endif
    output logic                     tx,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     ovf
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int BDW = $clog2(CLKS_PER_BIT);
    localparam int BIW = $clog2(DATA_W);

    localparam logic [BDW-1:0] BAUD_LAST = BDW'(CLKS_PER_BIT - 1);
    localparam logic [BIW-1:0] BIT_LAST  = BIW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_nxt;
    logic              push;
    logic              pop;
    logic              can_go;
    logic              idle_tx;

    logic [BDW-1:0]    baud;
    logic [BIW-1:0]    bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              par_en;
    logic              par_bit;
    logic              stop_two;
    logic              stop_cnt;

`ifdef UART_TX_BREAK_EN
    localparam int GW = $clog2(CLKS_PER_BIT + 1);
    logic [GW-1:0] gap_cnt;

    // After brk drops, tx must sit high a full bit period before a new
    // start bit so the receiver sees a clean mark after the break.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (state == IDLE) begin
            if (brk)
                gap_cnt <= GW'(CLKS_PER_BIT);
            else if (gap_cnt != '0)
                gap_cnt <= gap_cnt - GW'(1);
        end
    end

    assign can_go  = !brk && (gap_cnt == '0);
    assign idle_tx = !brk;
`else
    assign can_go  = 1'b1;
    assign idle_tx = 1'b1;
`endif

    // Flags are registered, so a push while full is refused even when a
    // pop frees a slot in the same cycle.
    assign push = wr_en && !full;
    assign pop  = (state == IDLE) && (start || auto_en) && !empty && can_go;

    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            wr_ready <= 1'b1;
            ovf      <= 1'b0;
        end else begin
            ovf      <= wr_en && full;
            count    <= count_nxt;
            empty    <= (count_nxt == '0);
            full     <= (count_nxt == CW'(DEPTH));
            wr_ready <= (count_nxt != CW'(DEPTH));
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            baud     <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_en   <= 1'b0;
            par_bit  <= 1'b0;
            stop_two <= 1'b0;
            stop_cnt <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    baud     <= '0;
                    bit_idx  <= '0;
                    stop_cnt <= 1'b0;
                    tx       <= idle_tx;
                    if (pop) begin
                        shreg    <= mem[rd_ptr];
                        // mode 11 has both bits set and means no parity
                        par_en   <= parity_mode[0] ^ parity_mode[1];
                        par_bit  <= (^mem[rd_ptr]) ^ parity_mode[1];
                        stop_two <= stop2;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud == BAUD_LAST) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        state   <= DATA;
                    end else begin
                        baud <= baud + BDW'(1);
                    end
                end
                DATA: begin
                    if (baud == BAUD_LAST) begin
                        baud <= '0;
                        if (bit_idx == BIT_LAST) begin
                            if (par_en) begin
                                tx    <= par_bit;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + BIW'(1);
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        baud <= baud + BDW'(1);
                    end
                end
                PARITY: begin
                    if (baud == BAUD_LAST) begin
                        baud  <= '0;
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        baud <= baud + BDW'(1);
                    end
                end
                STOP: begin
                    if (baud == BAUD_LAST) begin
                        baud <= '0;
                        if (stop_two && !stop_cnt) begin
                            stop_cnt <= 1'b1;
                        end else begin
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + BDW'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO. It is the next generation of the board-level serial transmit path. Frames are pushed from the user side (switches, button logic or a host block), queued in order, and serialised onto `tx`. Frames go out one at a time on a `start` pulse, or continuously while `auto_en` is high. Data width, FIFO depth and baud divisor are compile-time parameters; parity mode and stop-bit count are runtime inputs.

## Interface
- `DATA_W`, 8: payload bits per frame (5–9).
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CLKS_PER_BIT`, 868: `clk` cycles per bit period (100 MHz / 115200); ≥2.
- `clk` input 1: single system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `wr_en` input 1: push request; accepted when `wr_en && wr_ready`.
- `wr_data` input `DATA_W`: payload to push.
- `wr_ready` output 1: high when the FIFO is not full.
- `start` input 1: single-cycle request to send one queued frame.
- `auto_en` input 1: level; when high, drains the FIFO back-to-back.
- `parity_mode` input 2: 00 none, 01 even, 10 odd, 11 treated as none.
- `stop2` input 1: 0 = one stop bit, 1 = two stop bits.
- `tx` output 1: serial line, idle high.
- `busy` output 1: high from frame start through the last stop bit.
- `done` output 1: one-cycle pulse at the end of each frame.
- `count` output `$clog2(DEPTH)+1`: current FIFO occupancy.
- `empty`, `full` output 1 each: FIFO flags.
- `ovf` output 1: one-cycle pulse when `wr_en` is high while full (write dropped).

## Operation
- FIFO: circular buffer, read and write pointers `$clog2(DEPTH)` wide with natural wrap. `count` is kept separately.
- Order is strictly first in, first out. The oldest entry is transmitted first.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Leaves when `(start || auto_en) && !empty`.
  - Pops the head into the shift register.
  - Latches `parity_mode` and `stop2` for the whole frame; changes mid-frame have no effect.
  - Goes to START.
  - `start` while empty is ignored, not queued.
- START: `tx`=0 for one bit period, then DATA.
- DATA:
  - Sends `DATA_W` bits LSB first; bit counter runs 0..`DATA_W`-1.
  - Then goes to PARITY if the latched mode is even or odd, otherwise to STOP.
- PARITY:
  - Even mode: `tx` = XOR of the payload.
  - Odd mode: `tx` = inverted XOR of the payload.
- STOP:
  - `tx`=1 for 1 or 2 bit periods.
  - Then `done` pulses and the FSM returns to IDLE.
- Baud counter:
  - Counts 0..`CLKS_PER_BIT`-1 and resets to 0 on each bit transition.
  - Held at 0 in IDLE.
- `start` during a frame is ignored.
- Push and pop in the same cycle:
  - Both take effect; `count` is unchanged.
  - When full, the push is refused even if a pop happens that cycle, because `wr_ready` is evaluated from the registered `full`.
- Push into an empty FIFO with `start` in the same cycle: `start` is ignored, since `empty` is sampled before the push.

## Timing
- All outputs are registered.
- Reset values: `tx`=1, `busy`=0, `done`=0, `count`=0, `empty`=1, `full`=0, `wr_ready`=1, `ovf`=0, FSM = IDLE, pointers = 0.
- Reset asserted mid-frame: `tx` returns high immediately (asynchronous) and all queued data is discarded.
- Start-up latency:
  - `start` sampled at edge N puts `tx` low and `busy` high from edge N.
  - `count` decrements at edge N.
- Frame length: (1 + `DATA_W` + P + S) × `CLKS_PER_BIT` cycles, where P ∈ {0,1} and S ∈ {1,2}.
- `done`:
  - Asserts for exactly one cycle, in the cycle when `busy` falls.
  - With `auto_en` high and the FIFO non-empty, the next start bit begins in the cycle after `done`. There is no extra idle gap.
- `count`, `full` and `empty` update at the edge of the accepted push or pop.

## Configuration
- `UART_TX_BREAK_EN` defined:
  - Adds input `brk` (1 bit).
  - While `brk` is high and the FSM is in IDLE, `tx` is driven 0 and no frame starts.
  - `brk` rising mid-frame takes effect only after the current frame's stop bit(s).
  - On `brk` release, `tx`=1 for at least one full bit period before any new frame starts.
- `UART_TX_BREAK_EN` undefined: no `brk` port; IDLE always drives `tx`=1.

## Test plan
- `CLKS_PER_BIT`=4, even parity, push 0x55, pulse `start` → `tx` bits 0,1,0,1,0,1,0,1,0,0,1, each 4 cycles; `busy` 44 cycles; `done` pulses once; `count` 1→0.
- Odd parity, `stop2`=1, push 0x00 → parity bit 1, two stop bits, 48-cycle frame.
- `DEPTH`=4: push 0x11,0x22,0x33,0x44 → `full`=1, `wr_ready`=0; fifth push 0x55 → `ovf` pulse, `count` stays 4. Then `auto_en`=1 → frames 0x11..0x44 back-to-back, no gap, `empty`=1 after the 4th pop.
- Wrap-around: alternate push/pop 10 times with `DEPTH`=4 → order preserved, `count` never exceeds 1.
- Reset: assert `rst_n`=0 mid-DATA → `tx`=1 and `count`=0 immediately; after release, `start` with the FIFO empty → no frame.
- `UART_TX_BREAK_EN`: `brk`=1 in IDLE with a queued byte and `auto_en`=1 → `tx`=0 and no pop; after release, `tx`=1 for ≥4 cycles, then the frame starts.
